// File: rtl/avmm_stream_uart_bridge.sv
// Avalon-MM character port bridging host register accesses to a pair of
// valid/ready byte streams through show-ahead TX and RX FIFOs.
module avmm_stream_uart_bridge #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned TX_LOG2       = 6,
  parameter int unsigned RX_LOG2       = 6,
  parameter int unsigned TX_THRESH_RST = 8,
  parameter int unsigned RX_THRESH_RST = 56
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        av_address,
  input  logic              av_chipselect,
  input  logic              av_read_n,
  input  logic              av_write_n,
  input  logic [31:0]       av_writedata,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic              av_irq,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              host_pause,
  output logic              dataavailable,
  output logic              readyfordata
);

  localparam int unsigned TxCw    = TX_LOG2 + 1;
  localparam int unsigned RxCw    = RX_LOG2 + 1;
  localparam int unsigned TxDepth = 1 << TX_LOG2;
  localparam int unsigned RxDepth = 1 << RX_LOG2;
  localparam logic [TxCw-1:0] TxFullCnt = TxCw'(TxDepth);
  localparam logic [RxCw-1:0] RxFullCnt = RxCw'(RxDepth);

  // FIFO storage and pointers
  logic [DATA_W-1:0]  tx_mem [TxDepth];
  logic [DATA_W-1:0]  rx_mem [RxDepth];
  logic [TX_LOG2-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [RX_LOG2-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [TxCw-1:0]    tx_count_q, tx_count_d;
  logic [RxCw-1:0]    rx_count_q, rx_count_d;

  // Host-visible control state
  logic        wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ien_rx_q, ien_rx_d, ien_tx_q, ien_tx_d;
  logic        ac_q, ac_d, wovf_q, wovf_d, pause_irq_q, pause_irq_d;
  logic [15:0] rx_thresh_q, rx_thresh_d, tx_thresh_q, tx_thresh_d;
  logic        rx_ge_q, rx_ge_d, tx_le_q, tx_le_d;
  logic        davail_q, davail_d, rfd_q, rfd_d;

  // Decoded strobes
  logic        access, wr_act, rd_act;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic        activity, ipen_rx, ipen_tx;
  logic [15:0] rx_thresh_eff;

  // Access decode; full/empty come from the count at the start of the cycle
  always_comb begin
    access   = av_chipselect & (~av_write_n | ~av_read_n) & wait_q;
    wr_act   = access & ~av_write_n;
    rd_act   = access & av_write_n;
    tx_empty = (tx_count_q == '0);
    tx_full  = (tx_count_q == TxFullCnt);
    rx_empty = (rx_count_q == '0);
    rx_full  = (rx_count_q == RxFullCnt);
    tx_push  = wr_act & (av_address == 2'd0) & ~tx_full;
    tx_pop   = ~tx_empty & tx_ready;
    tx_flush = wr_act & (av_address == 2'd3) & av_writedata[0];
    rx_push  = rx_valid & ~rx_full;
    rx_pop   = rd_act & (av_address == 2'd0) & ~rx_empty;
    rx_flush = wr_act & (av_address == 2'd3) & av_writedata[1];
    activity = host_pause | rx_push;
    ipen_rx  = ien_rx_q & (pause_irq_q | rx_ge_q);
    ipen_tx  = ien_tx_q & tx_le_q;
  end

  // FIFO pointer and count next-state; flush overrides any push/pop
  always_comb begin
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_count_d = tx_count_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_count_d = rx_count_q;
    if (tx_flush) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      tx_count_d = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
      tx_count_d = tx_count_q + TxCw'(tx_push) - TxCw'(tx_pop);
    end
    if (rx_flush) begin
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      rx_count_d = '0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
      rx_count_d = rx_count_q + RxCw'(rx_push) - RxCw'(rx_pop);
    end
  end

  // Register file updates, interrupt conditions and read data capture
  always_comb begin
    wait_d      = ~access;
    rdata_d     = rdata_q;
    ien_rx_d    = ien_rx_q;
    ien_tx_d    = ien_tx_q;
    ac_d        = ac_q;
    wovf_d      = wovf_q;
    pause_irq_d = pause_irq_q;
    rx_thresh_d = rx_thresh_q;
    tx_thresh_d = tx_thresh_q;

    if (wr_act) begin
      unique case (av_address)
        2'd0: if (tx_full) wovf_d = 1'b1;
        2'd1: begin
          ien_rx_d = av_writedata[0];
          ien_tx_d = av_writedata[1];
          if (av_writedata[10]) ac_d = 1'b0;
          if (av_writedata[11]) wovf_d = 1'b0;
        end
        2'd2: begin
          rx_thresh_d = av_writedata[15:0];
          tx_thresh_d = av_writedata[31:16];
        end
        default: ;
      endcase
    end
    // Activity beats a same-cycle clear
    if (activity) ac_d = 1'b1;

    if (rd_act && av_address == 2'd0) pause_irq_d = 1'b0;
    if (host_pause && !rx_empty)     pause_irq_d = 1'b1;

    if (rd_act) begin
      rdata_d = '0;
      unique case (av_address)
        2'd0: begin
          rdata_d[31:16] = 16'(rx_count_q - RxCw'(rx_pop));
          rdata_d[15]    = ~rx_empty;
          if (!rx_empty) rdata_d[DATA_W-1:0] = rx_mem[rx_rptr_q];
        end
        2'd1: begin
          rdata_d[31:16] = 16'(TxFullCnt - tx_count_q);
          rdata_d[11]    = wovf_q;
          rdata_d[10]    = ac_q;
          rdata_d[9]     = ipen_tx;
          rdata_d[8]     = ipen_rx;
          rdata_d[1]     = ien_tx_q;
          rdata_d[0]     = ien_rx_q;
        end
        2'd2: rdata_d = {tx_thresh_q, rx_thresh_q};
        default: ;
      endcase
    end

    // A zero RX threshold would fire on an empty FIFO, so treat it as 1
    rx_thresh_eff = (rx_thresh_q == '0) ? 16'd1 : rx_thresh_q;
    rx_ge_d       = (16'(rx_count_q) >= rx_thresh_eff);
    tx_le_d       = (16'(tx_count_q) <= tx_thresh_q);
    davail_d      = (rx_count_d != '0);
    rfd_d         = (tx_count_d != TxFullCnt);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q      <= 1'b1;
      rdata_q     <= '0;
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      tx_count_q  <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      rx_count_q  <= '0;
      ien_rx_q    <= 1'b0;
      ien_tx_q    <= 1'b0;
      ac_q        <= 1'b0;
      wovf_q      <= 1'b0;
      pause_irq_q <= 1'b0;
      rx_thresh_q <= 16'(RX_THRESH_RST);
      tx_thresh_q <= 16'(TX_THRESH_RST);
      rx_ge_q     <= 1'b0;
      tx_le_q     <= 1'b0;
      davail_q    <= 1'b0;
      rfd_q       <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      rdata_q     <= rdata_d;
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      tx_count_q  <= tx_count_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      rx_count_q  <= rx_count_d;
      ien_rx_q    <= ien_rx_d;
      ien_tx_q    <= ien_tx_d;
      ac_q        <= ac_d;
      wovf_q      <= wovf_d;
      pause_irq_q <= pause_irq_d;
      rx_thresh_q <= rx_thresh_d;
      tx_thresh_q <= tx_thresh_d;
      rx_ge_q     <= rx_ge_d;
      tx_le_q     <= tx_le_d;
      davail_q    <= davail_d;
      rfd_q       <= rfd_d;
    end
  end

  // FIFO storage writes (no reset needed; contents gated by counts)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= av_writedata[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
  end

  assign av_waitrequest = wait_q;
  assign av_readdata    = rdata_q;
  assign av_irq         = ipen_rx | ipen_tx;
  assign tx_valid       = ~tx_empty;
  assign tx_data        = tx_mem[tx_rptr_q];
  assign rx_ready       = ~rx_full;
  assign dataavailable  = davail_q;
  assign readyfordata   = rfd_q;

endmodule

// File: tb/tb_avmm_stream_uart_bridge.sv
// Scoreboard bench: expected read data and TX beats are queued at issue time
// from a queue-based model; a negedge monitor compares as the DUT presents them.
module tb_avmm_stream_uart_bridge;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  av_address = '0;
  logic        av_chipselect = 1'b0, av_read_n = 1'b1, av_write_n = 1'b1;
  logic [31:0] av_writedata = '0;
  logic [31:0] av_readdata;
  logic        av_waitrequest, av_irq;
  logic [7:0]  tx_data, rx_data = '0;
  logic        tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready;
  logic        host_pause = 1'b0, dataavailable, readyfordata;

  always #5 clk = ~clk;

  avmm_stream_uart_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .av_address(av_address), .av_chipselect(av_chipselect),
    .av_read_n(av_read_n), .av_write_n(av_write_n), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest), .av_irq(av_irq),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .host_pause(host_pause), .dataavailable(dataavailable), .readyfordata(readyfordata)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain queues and flags
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  bit          ien_rx_m, ien_tx_m, ac_m, wovf_m, pause_m;
  logic [15:0] rx_th_m = 16'd56, tx_th_m = 16'd8;

  // Read-data scoreboard
  logic [31:0] rd_exp_q[$];
  bit          rd_isrd_q[$];
  string       rd_name_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic bit ipen_rx_m();
    int th = (rx_th_m == 16'd0) ? 1 : int'(rx_th_m);
    return ien_rx_m && (pause_m || rx_q.size() >= th);
  endfunction

  function automatic bit ipen_tx_m();
    return ien_tx_m && (tx_q.size() <= int'(tx_th_m));
  endfunction

  function automatic logic [31:0] irq_m();
    return 32'(ipen_rx_m() | ipen_tx_m());
  endfunction

  task automatic model_access(input logic [1:0] a, input bit wr, input logic [31:0] d,
                              output logic [31:0] e);
    e = '0;
    case (a)
      2'd0: if (wr) begin
        if (tx_q.size() < DEPTH) tx_q.push_back(d[7:0]);
        else wovf_m = 1'b1;
      end else begin
        if (rx_q.size() > 0) begin
          e = {16'(rx_q.size() - 1), 1'b1, 7'b0, rx_q[0]};
          void'(rx_q.pop_front());
        end
        pause_m = 1'b0;
      end
      2'd1: if (wr) begin
        ien_rx_m = d[0];
        ien_tx_m = d[1];
        if (d[10]) ac_m = 1'b0;
        if (d[11]) wovf_m = 1'b0;
      end else begin
        e = {16'(DEPTH - tx_q.size()), 4'b0, wovf_m, ac_m, ipen_tx_m(), ipen_rx_m(),
             6'b0, ien_tx_m, ien_rx_m};
      end
      2'd2: if (wr) begin
        rx_th_m = d[15:0];
        tx_th_m = d[31:16];
      end else begin
        e = {tx_th_m, rx_th_m};
      end
      default: if (wr) begin
        if (d[0]) tx_q.delete();
        if (d[1]) rx_q.delete();
      end
    endcase
  endtask

  // All driver tasks start and end 1 time unit after a rising edge
  task automatic av_start(input logic [1:0] a, input bit wr, input logic [31:0] d,
                          input string nm);
    logic [31:0] e;
    model_access(a, wr, d, e);
    rd_exp_q.push_back(e);
    rd_isrd_q.push_back(!wr);
    rd_name_q.push_back(nm);
    av_address    = a;
    av_chipselect = 1'b1;
    av_write_n    = !wr;
    av_read_n     = wr;
    av_writedata  = d;
  endtask

  task automatic av_finish();
    check("waitreq_low_after_action", 32'(av_waitrequest), 32'd0);
    @(posedge clk); #1;
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_read_n     = 1'b1;
    check("waitreq_high_after_access", 32'(av_waitrequest), 32'd1);
  endtask

  task automatic av_access(input logic [1:0] a, input bit wr, input logic [31:0] d,
                           input string nm);
    av_start(a, wr, d, nm);
    @(posedge clk); #1;
    av_finish();
  endtask

  // Holds rx_valid high for one edge; caller drops it when the burst ends
  task automatic rx_send(input logic [7:0] d);
    bit acc;
    rx_data  = d;
    rx_valid = 1'b1;
    acc = (rx_q.size() < DEPTH);
    check("rx_ready", 32'(rx_ready), 32'(acc));
    if (acc) begin
      rx_q.push_back(d);
      ac_m = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compares read data on the wait-low cycle and TX beats on handshake
  logic [31:0] mon_v;
  bit          mon_rd;
  string       mon_nm;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!av_waitrequest) begin
        if (rd_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack readdata 0x%08h with nothing issued", av_readdata);
        end else begin
          mon_v  = rd_exp_q.pop_front();
          mon_rd = rd_isrd_q.pop_front();
          mon_nm = rd_name_q.pop_front();
          if (mon_rd) check(mon_nm, av_readdata, mon_v);
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_extra_beat got 0x%02h want no beat", tx_data);
        end else begin
          check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int m;
    logic [31:0] r;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_waitrequest", 32'(av_waitrequest), 32'd1);
    check("rst_readdata", av_readdata, 32'd0);
    check("rst_irq", 32'(av_irq), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_dataavailable", 32'(dataavailable), 32'd0);
    check("rst_readyfordata", 32'(readyfordata), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    av_access(2'd1, 1'b0, '0, "ctrl_after_reset");
    av_access(2'd2, 1'b0, '0, "thresh_after_reset");
    r = $urandom;
    av_access(2'd2, 1'b1, r, "");
    av_access(2'd2, 1'b0, '0, "thresh_random");
    av_access(2'd3, 1'b0, '0, "addr3_read");

    // TX threshold interrupt and TX flush
    av_access(2'd2, 1'b1, {16'd2, 16'd56}, "");
    av_access(2'd1, 1'b1, 32'h2, "");
    check("irq_tx_empty", 32'(av_irq), irq_m());
    for (int i = 0; i < 3; i++) av_access(2'd0, 1'b1, 32'($urandom_range(0, 255)), "");
    check("irq_tx_above_thresh", 32'(av_irq), irq_m());
    av_access(2'd3, 1'b1, 32'h1, "");
    check("irq_tx_after_flush", 32'(av_irq), irq_m());
    check("tx_valid_after_flush", 32'(tx_valid), 32'd0);
    av_access(2'd1, 1'b1, 32'h0, "");
    av_access(2'd2, 1'b1, {16'd8, 16'd56}, "");

    // Fill TX past full with the stream stalled, then drain
    for (int i = 0; i <= 64; i++) begin
      av_access(2'd0, 1'b1, 32'(i), "");
      check("readyfordata", 32'(readyfordata), 32'(tx_q.size() < DEPTH));
    end
    av_access(2'd1, 1'b0, '0, "ctrl_tx_full_overflow");
    tx_ready = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check("tx_beats_missing", 32'(tx_q.size()), 32'd0);
    check("tx_valid_drained", 32'(tx_valid), 32'd0);
    av_access(2'd1, 1'b1, 32'h800, "");
    av_access(2'd1, 1'b0, '0, "ctrl_overflow_cleared");

    // Three RX bytes, four reads
    rx_send(8'h41);
    rx_send(8'h42);
    rx_send(8'h43);
    rx_valid = 1'b0;
    check("dataavailable_full", 32'(dataavailable), 32'd1);
    for (int i = 0; i < 4; i++) av_access(2'd0, 1'b0, '0, "rx_read");
    check("dataavailable_empty", 32'(dataavailable), 32'd0);

    // RX threshold interrupt with one-cycle latency
    av_access(2'd2, 1'b1, {16'd8, 16'd4}, "");
    av_access(2'd1, 1'b1, 32'h1, "");
    check("irq_rx_idle", 32'(av_irq), 32'd0);
    for (int i = 0; i < 4; i++) rx_send(8'(8'h50 + i));
    rx_valid = 1'b0;
    check("irq_rx_same_cycle", 32'(av_irq), 32'd0);
    @(posedge clk); #1;
    check("irq_rx_thresh", 32'(av_irq), irq_m());
    av_access(2'd0, 1'b0, '0, "rx_read_thresh");
    check("irq_rx_below", 32'(av_irq), irq_m());

    // Pause interrupt and activity flag
    av_access(2'd2, 1'b1, {16'd8, 16'd56}, "");
    av_access(2'd0, 1'b0, '0, "rx_read_drain");
    av_access(2'd0, 1'b0, '0, "rx_read_drain");
    av_access(2'd1, 1'b1, 32'h401, "");
    av_access(2'd1, 1'b0, '0, "ctrl_ac_cleared");
    host_pause = 1'b1;
    ac_m = 1'b1;
    if (rx_q.size() > 0) pause_m = 1'b1;
    @(posedge clk); #1;
    host_pause = 1'b0;
    @(posedge clk); #1;
    check("irq_pause", 32'(av_irq), irq_m());
    av_access(2'd1, 1'b0, '0, "ctrl_pause");
    av_access(2'd0, 1'b0, '0, "rx_read_pause");
    check("irq_pause_cleared", 32'(av_irq), irq_m());
    av_access(2'd1, 1'b1, 32'h401, "");
    av_access(2'd1, 1'b0, '0, "ctrl_ac_recleared");
    av_access(2'd1, 1'b1, 32'h0, "");

    // Fill RX, then flush while a beat is offered
    for (int i = 0; i < DEPTH; i++) rx_send(8'($urandom_range(0, 255)));
    rx_send(8'hEE);
    check("rx_ready_full", 32'(rx_ready), 32'd0);
    av_start(2'd3, 1'b1, 32'h2, "");
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("rx_ready_after_flush", 32'(rx_ready), 32'd1);
    av_finish();
    av_access(2'd0, 1'b0, '0, "rx_read_after_flush");
    check("dataavailable_after_flush", 32'(dataavailable), 32'd0);

    // Randomised concurrent traffic on both streams
    n = $urandom_range(10, 40);
    m = $urandom_range(10, 40);
    fork
      begin
        for (int i = 0; i < n; i++) av_access(2'd0, 1'b1, $urandom, "");
      end
      begin
        for (int i = 0; i < m; i++) begin
          if ($urandom_range(0, 1) == 1) rx_send(8'($urandom_range(0, 255)));
          else begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        rx_valid = 1'b0;
      end
      begin
        repeat (60) begin
          tx_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    tx_ready = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check("tx_random_missing", 32'(tx_q.size()), 32'd0);
    m = rx_q.size();
    for (int i = 0; i <= m; i++) av_access(2'd0, 1'b0, '0, "rx_read_random");

    // Reset in the middle of a pending access
    for (int i = 0; i < 3; i++) av_access(2'd0, 1'b1, 32'(i + 7), "");
    av_address    = 2'd1;
    av_chipselect = 1'b1;
    av_write_n    = 1'b0;
    av_writedata  = 32'h3;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_waitrequest", 32'(av_waitrequest), 32'd1);
    check("midrst_readdata", av_readdata, 32'd0);
    check("midrst_readyfordata", 32'(readyfordata), 32'd0);
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    tx_q.delete();
    rx_q.delete();
    {ien_rx_m, ien_tx_m, ac_m, wovf_m, pause_m} = '0;
    rx_th_m = 16'd56;
    tx_th_m = 16'd8;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    av_access(2'd1, 1'b0, '0, "ctrl_after_midrst");
    av_access(2'd2, 1'b0, '0, "thresh_after_midrst");
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
